// File: rtl/md_pkg.sv
// Shared multiply/divide op encodings and decode helpers for the E-stage MD unit.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU decode).
package md_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'h0,
    MD_MULTU = 4'h1,
    MD_DIV   = 4'h2,
    MD_DIVU  = 4'h3,
    MD_MTHI  = 4'h4,
    MD_MTLO  = 4'h5,
    MD_MFHI  = 4'h6,
    MD_MFLO  = 4'h7,
    MD_MADD  = 4'h8,
    MD_MADDU = 4'h9,
    MD_MSUB  = 4'hA,
    MD_MSUBU = 4'hB
  } md_op_e;

  // Accumulate ops only count as compute ops when the feature is built in.
  function automatic logic op_is_compute(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Loadable down-counter that holds busy for (load value + 1) cycles and flags the final cycle.
module md_busy_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // The counter parks at zero once done; only a new load moves it again.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/e_md_unit.sv
// E-stage multiply/divide unit with HI/LO registers and fixed-latency busy modelling.
// Optional feature macro: MD_MADD_EN (multiply-accumulate/subtract into HI/LO).
module e_md_unit import md_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              md_start,
  input  logic [3:0]        md_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              d_is_md,
  output logic              busy,
  output logic              md_stall,
  output logic [DATA_W-1:0] md_rdata
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;
  logic              ctr_done, start_ok, is_compute, ctr_load;
  logic [DATA_W-1:0] res_hi, res_lo;
  logic              res_wr;

  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic                div_zero, div_ovf;
  logic [DATA_W-1:0]   b_safe_s, b_safe_u;
  logic signed [DATA_W-1:0] a_s, b_s, quot_s, rem_s;
  logic [DATA_W-1:0]   quot_u, rem_u;

  assign start_ok   = md_start && !busy;
  assign is_compute = op_is_compute(md_op);
  assign ctr_load   = start_ok && is_compute;

  md_busy_ctr #(.CNT_W(CNT_W)) u_busy_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ctr_load),
    .load_val_i (op_is_div(md_op) ? DIV_LOAD : MULT_LOAD),
    .busy_o     (busy),
    .done_o     (ctr_done)
  );

  // Low 2*DATA_W bits of the extended-operand product give the signed/unsigned result.
  assign prod_s = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};
  assign prod_u = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};

  // Divisors are replaced by 1 in the cases whose result is decided separately.
  assign div_zero = (src_b == '0);
  assign div_ovf  = (src_a == S_MIN) && (src_b == '1);
  assign b_safe_s = (div_zero || div_ovf) ? DATA_W'(1) : src_b;
  assign b_safe_u = div_zero ? DATA_W'(1) : src_b;
  assign a_s      = src_a;
  assign b_s      = b_safe_s;
  assign quot_s   = a_s / b_s;
  assign rem_s    = a_s % b_s;
  assign quot_u   = src_a / b_safe_u;
  assign rem_u    = src_a % b_safe_u;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b1;
    case (md_op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (div_zero)     res_wr = 1'b0;
        else if (div_ovf) {res_hi, res_lo} = {{DATA_W{1'b0}}, S_MIN};
        else              {res_hi, res_lo} = {rem_s, quot_s};
      end
      MD_DIVU: begin
        if (div_zero) res_wr = 1'b0;
        else          {res_hi, res_lo} = {rem_u, quot_u};
      end
`ifdef MD_MADD_EN
      MD_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      MD_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      MD_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
      MD_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
      default: res_wr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // HI/LO change only on a commit or an MTHI/MTLO issued while idle.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (ctr_done) begin
      if (pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start_ok) begin
      if (is_compute) begin
        pend_hi_d = res_hi;
        pend_lo_d = res_lo;
        pend_wr_d = res_wr;
      end else if (md_op == MD_MTHI) begin
        hi_d = src_a;
      end else if (md_op == MD_MTLO) begin
        lo_d = src_a;
      end
    end
  end

  assign md_stall = d_is_md && (busy || (md_start && is_compute));
  assign md_rdata = (md_op == MD_MFHI) ? hi_q :
                    (md_op == MD_MFLO) ? lo_q : '0;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) assert (!(md_start && busy));
  end
`endif

endmodule

// File: tb/tb_e_md_unit.sv
// Directed bench for e_md_unit: op table with hand-computed HI/LO plus stall/reset/MADD sequences.
module tb_e_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        d_is_md;
  logic        busy, md_stall;
  logic [31:0] md_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e_md_unit #(.DATA_W(32), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .md_rdata (md_rdata)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] expHi;
    logic [31:0] expLo;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one op, then counts busy cycles (bounded) until the unit is idle again.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int busyCycles);
    @(negedge clk);
    md_start = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    md_start   = 1'b0;
    busyCycles = 0;
    while (busy && busyCycles < 40) begin
      busyCycles++;
      @(negedge clk);
    end
  endtask

  task automatic readReg(input logic [3:0] op, output logic [31:0] value);
    md_op = op;
    #1;
    value = md_rdata;
  endtask

  task automatic checkHiLo(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] v;
    readReg(MD_MFHI, v);
    checkOutput({name, " HI"}, v, expHi);
    readReg(MD_MFLO, v);
    checkOutput({name, " LO"}, v, expLo);
  endtask

  initial begin
    int n;
    int stallCnt;
    logic [31:0] v;

    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2*3"};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001, "multu max*max"};
    vecs[2]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003, "divu 7/2"};
    vecs[3]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
    vecs[4]  = '{MD_MTHI,  32'h0000_0011, 32'h0000_0000, 0,  32'h0000_0011, 32'hFFFF_FFFD, "mthi 0x11"};
    vecs[5]  = '{MD_MTLO,  32'h0000_0022, 32'h0000_0000, 0,  32'h0000_0011, 32'h0000_0022, "mtlo 0x22"};
    vecs[6]  = '{MD_DIV,   32'h0000_0005, 32'h0000_0000, 10, 32'h0000_0011, 32'h0000_0022, "div by zero"};
    vecs[7]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div min/-1"};
    vecs[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2"};
    vecs[9]  = '{4'hF,     32'h0000_0005, 32'h0000_0009, 0,  32'h0000_0001, 32'hFFFF_FFFD, "undef op"};
    vecs[10] = '{MD_MULT,  32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000, "mult 2^16*2^16"};

    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = MD_MFHI;
    src_a    = '0;
    src_b    = '0;
    d_is_md  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset stall", 32'(md_stall), 32'd0);
    checkHiLo("reset", 32'h0, 32'h0);
    reset   = 1'b0;
    d_is_md = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, n);
      checkOutput({vecs[i].name, " busy cycles"}, 32'(n), 32'(vecs[i].lat));
      checkHiLo(vecs[i].name, vecs[i].expHi, vecs[i].expLo);
    end

    // MFLO during a multiply still sees the old committed LO.
    applyStimulus(MD_MTLO, 32'h0000_1234, 32'h0, n);
    @(negedge clk);
    md_start = 1'b1;
    md_op    = MD_MULT;
    src_a    = 32'hFFFF_FFFE;
    src_b    = 32'h0000_0003;
    @(negedge clk);
    md_start = 1'b0;
    readReg(MD_MFLO, v);
    checkOutput("mflo during busy", v, 32'h0000_1234);
    checkOutput("busy after start", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mult busy remaining", 32'(n), 32'd5);
    checkHiLo("mult after busy", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // Stall with and without an MD instruction waiting in D.
    for (int pass = 0; pass < 2; pass++) begin
      d_is_md = (pass == 0);
      @(negedge clk);
      md_start = 1'b1;
      md_op    = MD_MULT;
      src_a    = 32'h0000_0002;
      src_b    = 32'h0000_0003;
      #1;
      checkOutput("stall at issue", 32'(md_stall), (pass == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      md_start = 1'b0;
      n        = 0;
      stallCnt = 0;
      while (busy && n < 40) begin
        n++;
        if (md_stall) stallCnt++;
        @(negedge clk);
      end
      checkOutput("stall busy cycles", 32'(n), 32'd5);
      checkOutput("stall cycle count", 32'(stallCnt), (pass == 0) ? 32'd5 : 32'd0);
      checkOutput("stall after commit", 32'(md_stall), 32'd0);
    end
    d_is_md = 1'b0;
    checkHiLo("mult 2*3", 32'h0, 32'h6);

    // Reset in the third busy cycle discards the pending result.
    @(negedge clk);
    md_start = 1'b1;
    md_op    = MD_MULT;
    src_a    = 32'hFFFF_FFFE;
    src_b    = 32'h0000_0003;
    @(negedge clk);
    md_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("reset mid-op busy", 32'(busy), 32'd0);
    checkHiLo("reset mid-op", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkHiLo("no late commit", 32'h0, 32'h0);
    applyStimulus(MD_MTLO, 32'h0000_0005, 32'h0, n);
    checkOutput("mtlo 5 busy cycles", 32'(n), 32'd0);
    checkHiLo("mtlo 5", 32'h0, 32'h5);

    // MADDU accumulate (or no-op when the feature is not built in).
    applyStimulus(MD_MTHI, 32'h0000_0000, 32'h0, n);
    applyStimulus(MD_MTLO, 32'hFFFF_FFFF, 32'h0, n);
    applyStimulus(MD_MADDU, 32'h0000_0001, 32'h0000_0001, n);
`ifdef MD_MADD_EN
    checkOutput("maddu busy cycles", 32'(n), 32'd5);
    checkHiLo("maddu 1*1", 32'h1, 32'h0);
`else
    checkOutput("maddu busy cycles", 32'(n), 32'd0);
    checkHiLo("maddu 1*1", 32'h0, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
